// File: rtl/audio_dac_pkg.sv
// Shared register map, STATUS bit positions and sample payload type for the
// audio_dac_fifo stereo sigma-delta output peripheral.
package audio_dac_pkg;

  localparam int unsigned SAMPLE_W = 16;

  // Word offsets decoded from addr[4:2]
  localparam logic [2:0] REG_DATA    = 3'd0;
  localparam logic [2:0] REG_STATUS  = 3'd1;
  localparam logic [2:0] REG_DIVIDER = 3'd2;
  localparam logic [2:0] REG_CTRL    = 3'd3;
  localparam logic [2:0] REG_VOLUME  = 3'd4;

  localparam int unsigned ST_FULL_BIT     = 8;
  localparam int unsigned ST_EMPTY_BIT    = 9;
  localparam int unsigned ST_UNDERRUN_BIT = 10;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] r;
    logic signed [SAMPLE_W-1:0] l;
  } stereo_sample_t;

endpackage

// File: rtl/audio_dac_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; dout shows the head entry
// combinationally. Flush equalises pointers and suppresses any coincident pop.
module audio_dac_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_c;
  logic             do_pop_c;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level = wr_q - rd_q;
  assign dout  = mem_q[rd_q[AW-1:0]];

  // A push into a full FIFO is legal when a pop frees the slot in the same cycle
  assign do_pop_c  = pop && !empty && !flush;
  assign do_push_c = push && (!full || do_pop_c);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push_c) wr_d = wr_q + PTR_ONE;
    if (do_pop_c)  rd_d = rd_q + PTR_ONE;
    if (flush)     rd_d = wr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/audio_dac_fifo.sv
// Memory-mapped stereo audio DAC: bus registers, sample FIFO, sample-rate tick
// and first-order sigma-delta modulators. Optional VOLUME register: AUDIO_DAC_VOLUME_EN.
module audio_dac_fifo
  import audio_dac_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd945
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  output logic        ready,
  input  logic [23:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        dsd_l,
  output logic        dsd_r
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                 ready_q, cooldown_q;
  logic [31:0]          rdata_q, rdata_d;
  logic                 dsd_l_q, dsd_r_q;
  logic [15:0]          div_q, div_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 en_q, en_d;
  logic                 underrun_q, underrun_d;
  stereo_sample_t       held_q, held_d;
  logic [15:0]          acc_l_q, acc_r_q;

  logic [2:0]           reg_off_c;
  logic                 is_write_c, req_c, stall_c, accept_c;
  logic                 push_c, pop_c, flush_c, tick_c;
  logic [15:0]          div_eff_c;
  logic [31:0]          read_c;
  stereo_sample_t       fifo_dout;
  logic [LVL_W-1:0]     fifo_level;
  logic                 fifo_full, fifo_empty;
  logic [15:0]          mod_l_c, mod_r_c;
  logic [16:0]          sum_l_c, sum_r_c;
  logic                 unused_c;

`ifdef AUDIO_DAC_VOLUME_EN
  logic [7:0]           vol_q, vol_d;
  logic signed [24:0]   prod_l_c, prod_r_c;
`endif

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign dsd_l = dsd_l_q;
  assign dsd_r = dsd_r_q;

  assign reg_off_c  = addr[4:2];
  assign is_write_c = |wstrb;
  assign tick_c     = en_q && (cnt_q == 16'd0);
  assign div_eff_c  = (div_q < 16'd2) ? 16'd2 : div_q;

  // Handshake: one action per access, then a cooldown cycle that masks sel
  assign req_c    = sel && !ready_q && !cooldown_q;
  assign flush_c  = req_c && is_write_c && (reg_off_c == REG_CTRL) && wdata[1];
  assign pop_c    = tick_c && !fifo_empty && !flush_c;
  assign stall_c  = req_c && is_write_c && (reg_off_c == REG_DATA) && fifo_full && !pop_c;
  assign accept_c = req_c && !stall_c;
  assign push_c   = accept_c && is_write_c && (reg_off_c == REG_DATA);

  audio_dac_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (resetn),
    .push  (push_c),
    .pop   (pop_c),
    .flush (flush_c),
    .din   (wdata),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Register read mux
  always_comb begin
    read_c = '0;
    case (reg_off_c)
      REG_STATUS: begin
        read_c[7:0]             = 8'(fifo_level);
        read_c[ST_FULL_BIT]     = fifo_full;
        read_c[ST_EMPTY_BIT]    = fifo_empty;
        read_c[ST_UNDERRUN_BIT] = underrun_q;
      end
      REG_DIVIDER: read_c = {16'd0, div_q};
      REG_CTRL:    read_c = {31'd0, en_q};
`ifdef AUDIO_DAC_VOLUME_EN
      REG_VOLUME:  read_c = {24'd0, vol_q};
`endif
      default:     read_c = '0;
    endcase
  end

  // Register writes, tick counter and held-sample update
  always_comb begin
    div_d   = div_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    rdata_d = '0;
`ifdef AUDIO_DAC_VOLUME_EN
    vol_d   = vol_q;
`endif
    // A tick on the flush cycle still reports underrun; set wins over clear
    underrun_d = (underrun_q && !flush_c) || (tick_c && (fifo_empty || flush_c));
    if (en_q) cnt_d = (cnt_q == 16'd0) ? (div_eff_c - 16'd1) : (cnt_q - 16'd1);
    if (pop_c) held_d = fifo_dout;
    if (accept_c) begin
      if (is_write_c) begin
        case (reg_off_c)
          REG_DIVIDER: div_d = wdata[15:0];
          REG_CTRL:    en_d  = wdata[0];
`ifdef AUDIO_DAC_VOLUME_EN
          REG_VOLUME:  vol_d = wdata[7:0];
`endif
          default: ;
        endcase
      end else begin
        rdata_d = read_c;
      end
    end
  end

`ifdef AUDIO_DAC_VOLUME_EN
  assign prod_l_c = (held_q.l * $signed({1'b0, vol_q})) >>> 8;
  assign prod_r_c = (held_q.r * $signed({1'b0, vol_q})) >>> 8;
  assign mod_l_c  = prod_l_c[15:0];
  assign mod_r_c  = prod_r_c[15:0];
  assign unused_c = ^{addr[23:5], addr[1:0], prod_l_c[24:16], prod_r_c[24:16]};
`else
  assign mod_l_c  = held_q.l;
  assign mod_r_c  = held_q.r;
  assign unused_c = ^{addr[23:5], addr[1:0]};
`endif

  // Offset-binary input, carry out of the 16-bit accumulator is the bitstream
  assign sum_l_c = {1'b0, acc_l_q} + {1'b0, mod_l_c ^ 16'h8000};
  assign sum_r_c = {1'b0, acc_r_q} + {1'b0, mod_r_c ^ 16'h8000};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q    <= 1'b0;
      cooldown_q <= 1'b0;
      rdata_q    <= '0;
      dsd_l_q    <= 1'b0;
      dsd_r_q    <= 1'b0;
      div_q      <= DIV_RESET;
      cnt_q      <= DIV_RESET - 16'd1;
      en_q       <= 1'b0;
      underrun_q <= 1'b0;
      held_q     <= '0;
      acc_l_q    <= '0;
      acc_r_q    <= '0;
`ifdef AUDIO_DAC_VOLUME_EN
      vol_q      <= 8'hFF;
`endif
    end else begin
      ready_q    <= accept_c;
      cooldown_q <= ready_q;
      rdata_q    <= rdata_d;
      dsd_l_q    <= sum_l_c[16];
      dsd_r_q    <= sum_r_c[16];
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      underrun_q <= underrun_d;
      held_q     <= held_d;
      acc_l_q    <= sum_l_c[15:0];
      acc_r_q    <= sum_r_c[15:0];
`ifdef AUDIO_DAC_VOLUME_EN
      vol_q      <= vol_d;
`endif
    end
  end

endmodule

// File: tb/tb_audio_dac_fifo.sv
// Self-checking bench for audio_dac_fifo: bus handshake, FIFO status, back-pressure,
// underrun, modulator density and async reset against a queue/arithmetic model.
module tb_audio_dac_fifo;
  import audio_dac_pkg::*;

  localparam logic [4:0] O_DATA    = {REG_DATA, 2'b00};
  localparam logic [4:0] O_STATUS  = {REG_STATUS, 2'b00};
  localparam logic [4:0] O_DIVIDER = {REG_DIVIDER, 2'b00};
  localparam logic [4:0] O_CTRL    = {REG_CTRL, 2'b00};
  localparam logic [4:0] O_VOLUME  = {REG_VOLUME, 2'b00};
  localparam int unsigned DEPTH    = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        sel = 1'b0;
  logic [23:0] addr = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] wdata = '0;
  logic        ready;
  logic [31:0] rdata;
  logic        dsd_l, dsd_r;

  int n_checks = 0;
  int n_pass = 0;

  stereo_sample_t model_q[$];
  bit             model_under = 1'b0;
`ifdef AUDIO_DAC_VOLUME_EN
  int             vol_m = 255;
`endif

  always #5 clk = ~clk;

  audio_dac_fifo dut (
    .clk    (clk),
    .resetn (resetn),
    .sel    (sel),
    .ready  (ready),
    .addr   (addr),
    .wstrb  (wstrb),
    .wdata  (wdata),
    .rdata  (rdata),
    .dsd_l  (dsd_l),
    .dsd_r  (dsd_r)
  );

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[7:0] = 8'(model_q.size());
    s[ST_FULL_BIT]     = (model_q.size() == DEPTH);
    s[ST_EMPTY_BIT]    = (model_q.size() == 0);
    s[ST_UNDERRUN_BIT] = model_under;
    return s;
  endfunction

  // Modulator input in offset binary, as the ideal density numerator over 65536
  function automatic longint exp_u(input logic [15:0] s);
    logic [15:0] v;
    v = s;
`ifdef AUDIO_DAC_VOLUME_EN
    v = 16'((int'($signed(s)) * vol_m) >>> 8);
`endif
    return longint'({48'd0, v ^ 16'h8000});
  endfunction

  function automatic longint dens_err(input int ones, input longint u);
    longint d;
    d = longint'(ones) * 65536 - 1024 * u;
    return (d < 0) ? -d : d;
  endfunction

  task automatic bus(input logic [4:0] off, input logic [3:0] ws, input logic [31:0] wd,
                     input int budget, input bit must_ack,
                     output logic [31:0] rd, output bit ok);
    @(posedge clk); #1;
    sel = 1'b1; addr = {19'd0, off}; wstrb = ws; wdata = wd;
    ok = 1'b0; rd = '0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (ready) begin ok = 1'b1; rd = rdata; end
    end
    @(posedge clk); #1;
    sel = 1'b0; wstrb = '0;
    if (must_ack && !ok) begin
      n_checks++;
      $display("FAIL bus_ack off=%h: no ready within %0d cycles", off, budget);
    end
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    logic [31:0] rd; bit ok;
    bus(off, 4'hF, d, 20, 1'b1, rd, ok);
  endtask

  task automatic rd_reg(input logic [4:0] off, output logic [31:0] v);
    bit ok;
    bus(off, 4'h0, 32'd0, 20, 1'b1, v, ok);
  endtask

  task automatic measure(output int ones_l, output int ones_r);
    ones_l = 0; ones_r = 0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      ones_l += int'(dsd_l);
      ones_r += int'(dsd_r);
    end
  endtask

  task automatic wait_level(input int want, input int max_reads, output bit ok);
    logic [31:0] v;
    ok = 1'b0;
    for (int i = 0; i < max_reads && !ok; i++) begin
      rd_reg(O_STATUS, v);
      if (int'(v[7:0]) == want) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    #2 resetn = 1'b0;
    #3;
    n_checks++;
    if ({ready, rdata, dsd_l, dsd_r} !== 35'd0)
      $display("FAIL reset_outputs: got %h want 0", {ready, rdata, dsd_l, dsd_r});
    else n_pass++;
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    rd_reg(O_STATUS, v);
    n_checks++; if (v !== 32'h0000_0200) $display("FAIL reset_status: got %h want %h", v, 32'h200); else n_pass++;
    rd_reg(O_DIVIDER, v);
    n_checks++; if (v !== 32'd945) $display("FAIL reset_divider: got %0d want 945", v); else n_pass++;
    rd_reg(O_CTRL, v);
    n_checks++; if (v !== 32'd0) $display("FAIL reset_ctrl: got %h want 0", v); else n_pass++;
  endtask

  task automatic test_handshake_push();
    logic [31:0] v;
    stereo_sample_t s;
    int pulses;
    for (int k = 0; k < 3; k++) begin
      s = stereo_sample_t'($urandom);
      @(posedge clk); #1;
      sel = 1'b1; addr = {19'd0, O_DATA}; wstrb = 4'hF; wdata = s;
      pulses = 0;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        if (ready) pulses++;
      end
      sel = 1'b0; wstrb = '0;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        if (ready) pulses++;
      end
      model_q.push_back(s);
      n_checks++; if (pulses != 1) $display("FAIL ready_pulses[%0d]: got %0d want 1", k, pulses); else n_pass++;
    end
    rd_reg(O_STATUS, v);
    n_checks++; if (v !== exp_status()) $display("FAIL push_level: got %h want %h", v, exp_status()); else n_pass++;
    rd_reg(O_DATA, v);
    n_checks++; if (v !== 32'd0) $display("FAIL data_read: got %h want 0", v); else n_pass++;
  endtask

  task automatic test_unmapped();
    logic [31:0] v, want10;
    logic [31:0] rd; bit ok;
`ifdef AUDIO_DAC_VOLUME_EN
    want10 = 32'h0000_00FF;
`else
    want10 = 32'd0;
`endif
    rd_reg(O_VOLUME, v);
    n_checks++; if (v !== want10) $display("FAIL off10_read: got %h want %h", v, want10); else n_pass++;
    rd_reg(5'h14, v);
    n_checks++; if (v !== 32'd0) $display("FAIL off14_read: got %h want 0", v); else n_pass++;
    bus(5'h1C, 4'hF, 32'hFFFF_FFFF, 20, 1'b0, rd, ok);
    n_checks++; if (!ok) $display("FAIL unmapped_write_ready: got 0 want 1"); else n_pass++;
    rd_reg(O_STATUS, v);
    n_checks++; if (v !== exp_status()) $display("FAIL unmapped_no_effect: got %h want %h", v, exp_status()); else n_pass++;
    bus(O_DIVIDER, 4'b0001, 32'h1234_5678, 20, 1'b1, rd, ok);
    rd_reg(O_DIVIDER, v);
    n_checks++; if (v !== 32'h0000_5678) $display("FAIL partial_wstrb: got %h want %h", v, 32'h5678); else n_pass++;
  endtask

  task automatic test_flush();
    logic [31:0] v;
    wr(O_CTRL, 32'd2);
    model_q.delete(); model_under = 1'b0;
    rd_reg(O_STATUS, v);
    n_checks++; if (v !== 32'h0000_0200) $display("FAIL flush_status: got %h want %h", v, 32'h200); else n_pass++;
    rd_reg(O_CTRL, v);
    n_checks++; if (v !== 32'd0) $display("FAIL flush_selfclear: got %h want 0", v); else n_pass++;
  endtask

  task automatic test_random_fill();
    logic [31:0] v;
    stereo_sample_t s;
    int n;
    for (int t = 0; t < 3; t++) begin
      n = int'($urandom_range(DEPTH, 1));
      for (int k = 0; k < n; k++) begin
        s = stereo_sample_t'($urandom);
        wr(O_DATA, s);
        model_q.push_back(s);
      end
      rd_reg(O_STATUS, v);
      n_checks++; if (v !== exp_status()) $display("FAIL fill_status[%0d]: got %h want %h", n, v, exp_status()); else n_pass++;
      wr(O_CTRL, 32'd2);
      model_q.delete();
    end
  endtask

  task automatic test_underrun();
    logic [31:0] v;
    stereo_sample_t s;
    int ol, orr;
    wr(O_DIVIDER, 32'd10);
    s.l = 16'sh7FFF; s.r = 16'($urandom);
    wr(O_DATA, s);
    wr(O_CTRL, 32'd1);
    repeat (1100) @(posedge clk);
    model_q.delete(); model_under = 1'b1;
    rd_reg(O_STATUS, v);
    n_checks++; if (v !== exp_status()) $display("FAIL underrun_status: got %h want %h", v, exp_status()); else n_pass++;
    measure(ol, orr);
    n_checks++; if (dens_err(ol, exp_u(s.l)) >= 65536) $display("FAIL underrun_dens_l: got %0d want ~%0d", ol, (exp_u(s.l) * 1024) / 65536); else n_pass++;
    n_checks++; if (dens_err(orr, exp_u(s.r)) >= 65536) $display("FAIL underrun_dens_r: got %0d want ~%0d", orr, (exp_u(s.r) * 1024) / 65536); else n_pass++;
  endtask

  task automatic test_midpoint();
    logic [31:0] v;
    stereo_sample_t s;
    int ol, orr;
    s.l = 16'sh0000; s.r = 16'sh8000;
    wr(O_DATA, s);
    repeat (30) @(posedge clk);
    measure(ol, orr);
    n_checks++; if (dens_err(ol, exp_u(s.l)) >= 65536) $display("FAIL mid_dens_l: got %0d want ~%0d", ol, (exp_u(s.l) * 1024) / 65536); else n_pass++;
    n_checks++; if (dens_err(orr, exp_u(s.r)) >= 65536) $display("FAIL mid_dens_r: got %0d want ~%0d", orr, (exp_u(s.r) * 1024) / 65536); else n_pass++;
    rd_reg(O_STATUS, v);
    n_checks++; if (v !== exp_status()) $display("FAIL sticky_underrun: got %h want %h", v, exp_status()); else n_pass++;
    wr(O_CTRL, 32'd2);
    model_under = 1'b0;
    rd_reg(O_STATUS, v);
    n_checks++; if (v !== exp_status()) $display("FAIL underrun_clear: got %h want %h", v, exp_status()); else n_pass++;
  endtask

  task automatic test_back_pressure();
    logic [31:0] v, rd;
    bit ok;
    stereo_sample_t s;
    wr(O_DIVIDER, 32'd2);
    for (int k = 0; k < DEPTH; k++) begin
      s = stereo_sample_t'($urandom);
      wr(O_DATA, s);
      model_q.push_back(s);
    end
    rd_reg(O_STATUS, v);
    n_checks++; if (v !== exp_status()) $display("FAIL full_status: got %h want %h", v, exp_status()); else n_pass++;
    s = stereo_sample_t'($urandom);
    bus(O_DATA, 4'hF, s, 100, 1'b0, rd, ok);
    n_checks++; if (ok) $display("FAIL stall_while_full: got ready=1 want 0"); else n_pass++;
    wr(O_DIVIDER, 32'd60);
    wr(O_CTRL, 32'd1);
    bus(O_DATA, 4'hF, s, 80, 1'b0, rd, ok);
    n_checks++; if (!ok) $display("FAIL stall_release: got ready=0 want 1"); else n_pass++;
    void'(model_q.pop_front());
    model_q.push_back(s);
    rd_reg(O_STATUS, v);
    n_checks++; if (v !== exp_status()) $display("FAIL refill_status: got %h want %h", v, exp_status()); else n_pass++;
    wr(O_CTRL, 32'd2);
    model_q.delete();
  endtask

  task automatic test_order();
    stereo_sample_t s;
    bit ok;
    int ol, orr;
    wr(O_DIVIDER, 32'd3000);
    for (int k = 0; k < 3; k++) begin
      s = stereo_sample_t'($urandom);
      wr(O_DATA, s);
      model_q.push_back(s);
    end
    wr(O_CTRL, 32'd1);
    for (int k = 0; k < 3; k++) begin
      wait_level(2 - k, 1500, ok);
      n_checks++; if (!ok) $display("FAIL pop_wait[%0d]: got timeout want level %0d", k, 2 - k); else n_pass++;
      s = model_q.pop_front();
      repeat (4) @(posedge clk);
      measure(ol, orr);
      n_checks++; if (dens_err(ol, exp_u(s.l)) >= 65536) $display("FAIL order_dens_l[%0d]: got %0d want ~%0d", k, ol, (exp_u(s.l) * 1024) / 65536); else n_pass++;
      n_checks++; if (dens_err(orr, exp_u(s.r)) >= 65536) $display("FAIL order_dens_r[%0d]: got %0d want ~%0d", k, orr, (exp_u(s.r) * 1024) / 65536); else n_pass++;
    end
    wr(O_CTRL, 32'd2);
    model_under = 1'b0;
  endtask

`ifdef AUDIO_DAC_VOLUME_EN
  task automatic test_volume();
    logic [31:0] v;
    stereo_sample_t s;
    bit ok;
    int ol, orr;
    wr(O_VOLUME, 32'h80);
    vol_m = 128;
    rd_reg(O_VOLUME, v);
    n_checks++; if (v !== 32'h80) $display("FAIL volume_read: got %h want 80", v); else n_pass++;
    s.l = 16'sh4000; s.r = 16'($urandom);
    wr(O_DATA, s);
    wr(O_CTRL, 32'd1);
    wait_level(0, 1500, ok);
    n_checks++; if (!ok) $display("FAIL volume_pop: got timeout want level 0"); else n_pass++;
    repeat (4) @(posedge clk);
    measure(ol, orr);
    n_checks++; if (dens_err(ol, 64'h0000_A000) >= 65536) $display("FAIL volume_dens_l: got %0d want ~640", ol); else n_pass++;
    n_checks++; if (dens_err(orr, exp_u(s.r)) >= 65536) $display("FAIL volume_dens_r: got %0d want ~%0d", orr, (exp_u(s.r) * 1024) / 65536); else n_pass++;
    wr(O_CTRL, 32'd2);
    wr(O_VOLUME, 32'hFF);
    vol_m = 255;
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] v;
    stereo_sample_t s;
    s = stereo_sample_t'($urandom);
    wr(O_DIVIDER, 32'd10);
    wr(O_DATA, s);
    wr(O_DATA, s);
    wr(O_CTRL, 32'd1);
    repeat (50) @(posedge clk);
    @(negedge clk); #2;
    resetn = 1'b0;
    #1;
    n_checks++; if (ready !== 1'b0) $display("FAIL async_ready: got %b want 0", ready); else n_pass++;
    n_checks++; if (rdata !== 32'd0) $display("FAIL async_rdata: got %h want 0", rdata); else n_pass++;
    n_checks++; if ({dsd_l, dsd_r} !== 2'b00) $display("FAIL async_dsd: got %b want 00", {dsd_l, dsd_r}); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    model_q.delete(); model_under = 1'b0;
    rd_reg(O_STATUS, v);
    n_checks++; if (v !== 32'h0000_0200) $display("FAIL post_reset_status: got %h want %h", v, 32'h200); else n_pass++;
    rd_reg(O_DIVIDER, v);
    n_checks++; if (v !== 32'd945) $display("FAIL post_reset_divider: got %0d want 945", v); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_handshake_push();
    test_unmapped();
    test_flush();
    test_random_fill();
    test_underrun();
    test_midpoint();
    test_back_pressure();
    test_order();
`ifdef AUDIO_DAC_VOLUME_EN
    test_volume();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
